// File: rtl/filter_pkg.sv
// Shared types and default settings for the pump array controller:
// FSM state encoding plus default duty, debounce and timeout values.
package filter_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_FILTER   = 3'd1,
        ST_DRAIN    = 3'd2,
        ST_STOPPING = 3'd3,
        ST_FAULT    = 3'd4
    } state_t;

    localparam int DEF_DUTY_BASE    = 128;
    localparam int DEF_DUTY_STEP    = 32;
    localparam int DEF_DUTY_DRAIN   = 255;
    localparam int DEF_DEBOUNCE_CYC = 16;
    localparam int DEF_TIMEOUT_CYC  = 1000000;

endpackage

// File: rtl/pwm_gen.sv
// Free-running PWM: counter wraps 2^PWM_W-1 -> 0, output high while counter < duty.
module pwm_gen #(
    parameter int PWM_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [PWM_W-1:0] duty,
    output logic             pwm
);

    logic [PWM_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!reset) cnt <= '0;
        else        cnt <= cnt + PWM_W'(1);
    end

    // duty 0 never satisfies the compare, so the output stays low
    assign pwm = (cnt < duty);

endmodule

// File: rtl/pump_array_ctrl.sv
// Water filter pump controller: 4-phase status handshake, debounced floats, FSM, two PWM pumps.
// Optional macro PUMP_SOFT_START_EN enables a slow upward ramp of the applied duties.
module pump_array_ctrl
    import filter_pkg::*;
#(
    parameter int DATA_W       = 4,
    parameter int PWM_W        = 8,
    parameter int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
    parameter int TIMEOUT_CYC  = DEF_TIMEOUT_CYC,
    parameter int DUTY_BASE    = DEF_DUTY_BASE,
    parameter int DUTY_STEP    = DEF_DUTY_STEP,
    parameter int DUTY_DRAIN   = DEF_DUTY_DRAIN
) (
    input  logic              clk_fpga,
    input  logic              reset,
    input  logic [DATA_W-1:0] i_dados,
    input  logic              i_req,
    output logic              o_ack,
    input  logic              i_boia_cheia,
    input  logic              i_boia_vazia,
    output logic              o_pwm_bomba_a,
    output logic              o_pwm_bomba_b,
    output logic [2:0]        o_state,
    output logic              o_fault
);

    localparam int DEB_W    = $clog2(DEBOUNCE_CYC + 1);
    localparam int DWELL_W  = $clog2(TIMEOUT_CYC + 1);
    localparam int SUM_W    = PWM_W + 4;
    localparam int DUTY_MAX = 2**PWM_W - 1;
    localparam logic [DWELL_W-1:0] DWELL_MAX = DWELL_W'(TIMEOUT_CYC);

    state_t              state;
    logic [1:0]          req_sync;
    logic [1:0]          f_meta, f_sync, deb;
    logic [DEB_W-1:0]    deb_cnt [2];
    logic [DATA_W-1:0]   status;
    logic [DWELL_W-1:0]  dwell;
    logic [SUM_W-1:0]    ones, duty_sum;
    logic [PWM_W-1:0]    target_a, target_b, duty_a, duty_b;
    logic                hs_evt, fault_cond, deb_cheia, deb_vazia;

    // Synchronisers and debounce; bit 0 carries the full float, bit 1 the empty float
    always_ff @(posedge clk_fpga) begin
        if (!reset) begin
            req_sync <= '0;
            f_meta   <= '0;
            f_sync   <= '0;
            deb      <= '0;
            for (int i = 0; i < 2; i++) deb_cnt[i] <= '0;
        end else begin
            req_sync <= {req_sync[0], i_req};
            f_meta   <= {i_boia_vazia, i_boia_cheia};
            f_sync   <= f_meta;
            for (int i = 0; i < 2; i++) begin
                if (f_sync[i] == deb[i]) begin
                    deb_cnt[i] <= '0;
                end else if (deb_cnt[i] == DEB_W'(DEBOUNCE_CYC - 1)) begin
                    deb[i]     <= f_sync[i];
                    deb_cnt[i] <= '0;
                end else begin
                    deb_cnt[i] <= deb_cnt[i] + DEB_W'(1);
                end
            end
        end
    end

    assign deb_cheia  = deb[0];
    assign deb_vazia  = deb[1];
    assign fault_cond = deb_cheia & deb_vazia;
    // Handshake: a status word is taken exactly once, when synced req is high and ack still low;
    // ack then stays high until synced req drops, so a held req cannot re-trigger.
    assign hs_evt     = req_sync[1] & ~o_ack;

    always_ff @(posedge clk_fpga) begin
        if (!reset) begin
            state   <= ST_IDLE;
            dwell   <= '0;
            o_fault <= 1'b0;
            o_ack   <= 1'b0;
            status  <= '0;
        end else begin
            if (hs_evt) begin
                o_ack  <= 1'b1;
                status <= i_dados;
            end else if (!req_sync[1] && o_ack) begin
                o_ack <= 1'b0;
            end

            if (dwell != DWELL_MAX) dwell <= dwell + DWELL_W'(1);

            if (fault_cond) begin
                if (state != ST_FAULT) begin
                    state <= ST_FAULT; dwell <= '0; o_fault <= 1'b1;
                end
            end else if (hs_evt) begin
                case (state)
                    ST_IDLE:
                        if (i_dados != '0) begin state <= ST_FILTER; dwell <= '0; end
                    ST_FILTER, ST_DRAIN:
                        if (i_dados == '0) begin state <= ST_STOPPING; dwell <= '0; end
                    ST_STOPPING:
                        if (i_dados != '0) begin state <= ST_FILTER; dwell <= '0; end
                    ST_FAULT:
                        if (i_dados == '0) begin state <= ST_IDLE; dwell <= '0; o_fault <= 1'b0; end
                    default: begin state <= ST_IDLE; dwell <= '0; end
                endcase
            end else begin
                case (state)
                    ST_FILTER:
                        if (deb_cheia) begin
                            state <= ST_DRAIN; dwell <= '0;
                        end else if (dwell == DWELL_MAX) begin
                            state <= ST_FAULT; dwell <= '0; o_fault <= 1'b1;
                        end
                    ST_DRAIN:
                        if (deb_vazia) begin
                            state <= (status != '0) ? ST_FILTER : ST_IDLE; dwell <= '0;
                        end
                    ST_STOPPING:
                        if (deb_vazia) begin state <= ST_IDLE; dwell <= '0; end
                    default: ;
                endcase
            end
        end
    end

    assign o_state = state;

    // Filter duty grows with the number of anomaly bits, saturated to the PWM range
    always_comb begin
        ones = '0;
        for (int i = 0; i < DATA_W; i++) ones = ones + SUM_W'(status[i]);
        duty_sum = SUM_W'(DUTY_BASE) + ones * SUM_W'(DUTY_STEP);
        target_a = '0;
        if (state == ST_FILTER)
            target_a = (duty_sum > SUM_W'(DUTY_MAX)) ? '1 : duty_sum[PWM_W-1:0];
        target_b = (state == ST_DRAIN || state == ST_STOPPING) ? PWM_W'(DUTY_DRAIN) : '0;
    end

`ifdef PUMP_SOFT_START_EN
    logic [PWM_W-5:0] ramp_cnt;

    always_ff @(posedge clk_fpga) begin
        if (!reset) begin
            ramp_cnt <= '0;
            duty_a   <= '0;
            duty_b   <= '0;
        end else begin
            ramp_cnt <= ramp_cnt + (PWM_W-4)'(1);
            if (target_a < duty_a)                        duty_a <= target_a;
            else if (ramp_cnt == '1 && duty_a < target_a) duty_a <= duty_a + PWM_W'(1);
            if (target_b < duty_b)                        duty_b <= target_b;
            else if (ramp_cnt == '1 && duty_b < target_b) duty_b <= duty_b + PWM_W'(1);
        end
    end
`else
    always_ff @(posedge clk_fpga) begin
        if (!reset) begin
            duty_a <= '0;
            duty_b <= '0;
        end else begin
            duty_a <= target_a;
            duty_b <= target_b;
        end
    end
`endif

    pwm_gen #(.PWM_W(PWM_W)) u_pwm_a (
        .clk   (clk_fpga),
        .reset (reset),
        .duty  (duty_a),
        .pwm   (o_pwm_bomba_a)
    );

    pwm_gen #(.PWM_W(PWM_W)) u_pwm_b (
        .clk   (clk_fpga),
        .reset (reset),
        .duty  (duty_b),
        .pwm   (o_pwm_bomba_b)
    );

endmodule

// File: tb/tb_pump_array_ctrl.sv
// Bench for pump_array_ctrl: a rule-level model checked every cycle plus directed literal checks.
module tb_pump_array_ctrl;

    localparam int DEB = 16;
    localparam int TO  = 400;

    logic       clk_fpga = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] i_dados = 4'h0;
    logic       i_req = 1'b0, i_boia_cheia = 1'b0, i_boia_vazia = 1'b0;
    logic       o_ack, o_pwm_bomba_a, o_pwm_bomba_b, o_fault;
    logic [2:0] o_state;

    int checks = 0;
    int failures = 0;

    always #5 clk_fpga = ~clk_fpga;

    pump_array_ctrl #(
        .DATA_W(4), .PWM_W(8), .DEBOUNCE_CYC(DEB), .TIMEOUT_CYC(TO),
        .DUTY_BASE(128), .DUTY_STEP(32), .DUTY_DRAIN(255)
    ) dut (
        .clk_fpga      (clk_fpga),
        .reset         (reset),
        .i_dados       (i_dados),
        .i_req         (i_req),
        .o_ack         (o_ack),
        .i_boia_cheia  (i_boia_cheia),
        .i_boia_vazia  (i_boia_vazia),
        .o_pwm_bomba_a (o_pwm_bomba_a),
        .o_pwm_bomba_b (o_pwm_bomba_b),
        .o_state       (o_state),
        .o_fault       (o_fault)
    );

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Inputs as seen by the DUT at each rising edge
    logic       c_rstn, c_req, c_cheia, c_vazia;
    logic [3:0] c_dados;
    bit         started = 1'b0;

    always @(posedge clk_fpga) begin
        c_rstn  <= reset;
        c_req   <= i_req;
        c_cheia <= i_boia_cheia;
        c_vazia <= i_boia_vazia;
        c_dados <= i_dados;
        started <= 1'b1;
    end

    // Model: inputs reach the logic two edges late; a float is accepted once its
    // last DEB synced samples all disagree with the accepted value.
    logic [2:0] m_state;
    logic [3:0] m_status;
    bit         m_ack, m_deb_c, m_deb_v;
    int         m_dwell, m_duty_a, m_duty_b, m_phase;
    bit         h_req [0:1];
    bit         h_c [0:DEB];
    bit         h_v [0:DEB];

    task automatic model_step();
        bit sreq, hs, flip_c, flip_v;
        logic [2:0] nxt;
        int tgt_a, tgt_b;
        if (!c_rstn) begin
            m_state = 3'd0; m_status = 4'h0; m_ack = 0; m_deb_c = 0; m_deb_v = 0;
            m_dwell = 0; m_duty_a = 0; m_duty_b = 0; m_phase = 0;
            h_req[0] = 0; h_req[1] = 0;
            for (int i = 0; i <= DEB; i++) begin h_c[i] = 0; h_v[i] = 0; end
        end else begin
            sreq = h_req[1];
            hs = sreq && !m_ack;
            tgt_a = 0;
            if (m_state == 3'd1) begin
                tgt_a = 128 + 32 * $countones(m_status);
                if (tgt_a > 255) tgt_a = 255;
            end
            tgt_b = (m_state == 3'd2 || m_state == 3'd3) ? 255 : 0;
            nxt = m_state;
            if (m_deb_c && m_deb_v) nxt = 3'd4;
            else if (hs) begin
                if (m_state == 3'd0 && c_dados != 0) nxt = 3'd1;
                if ((m_state == 3'd1 || m_state == 3'd2) && c_dados == 0) nxt = 3'd3;
                if (m_state == 3'd3 && c_dados != 0) nxt = 3'd1;
                if (m_state == 3'd4 && c_dados == 0) nxt = 3'd0;
            end else if (m_state == 3'd1 && m_deb_c) nxt = 3'd2;
            else if (m_state == 3'd2 && m_deb_v) nxt = (m_status != 0) ? 3'd1 : 3'd0;
            else if (m_state == 3'd3 && m_deb_v) nxt = 3'd0;
            else if (m_state == 3'd1 && m_dwell >= TO) nxt = 3'd4;
            if (nxt != m_state) m_dwell = 0;
            else if (m_dwell < TO) m_dwell++;
            m_state = nxt;
            if (hs) begin m_ack = 1; m_status = c_dados; end
            else if (!sreq && m_ack) m_ack = 0;
            flip_c = 1; flip_v = 1;
            for (int i = 1; i <= DEB; i++) begin
                if (h_c[i] == m_deb_c) flip_c = 0;
                if (h_v[i] == m_deb_v) flip_v = 0;
            end
            if (flip_c) m_deb_c = !m_deb_c;
            if (flip_v) m_deb_v = !m_deb_v;
            for (int i = DEB; i >= 1; i--) begin h_c[i] = h_c[i-1]; h_v[i] = h_v[i-1]; end
            h_c[0] = c_cheia; h_v[0] = c_vazia;
            h_req[1] = h_req[0]; h_req[0] = c_req;
            m_duty_a = tgt_a; m_duty_b = tgt_b;
            m_phase = (m_phase + 1) % 256;
        end
    endtask

    always @(negedge clk_fpga) begin
        logic [6:0] exp_v, act_v;
        if (started) begin
            model_step();
            exp_v = {m_ack, m_state, (m_state == 3'd4), (m_phase < m_duty_a), (m_phase < m_duty_b)};
            act_v = {o_ack, o_state, o_fault, o_pwm_bomba_a, o_pwm_bomba_b};
            checks++;
            if (act_v !== exp_v) begin
                failures++;
                $display("FAIL cycle_model {ack,state,fault,pa,pb} actual=%b required=%b (t=%0t)",
                         act_v, exp_v, $time);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin @(posedge clk_fpga); #1; end
    endtask

    task automatic handshake(input logic [3:0] d, input int exp_state, input string name);
        int n;
        i_dados = d; i_req = 1'b1; n = 0;
        while (!o_ack && n < 20) begin tick(1); n++; end
        check({name, "_ack_latency"}, n, 3);
        check({name, "_state"}, o_state, exp_state);
        i_req = 1'b0; n = 0;
        while (o_ack && n < 20) begin tick(1); n++; end
        check({name, "_ack_fall"}, n, 3);
    endtask

    task automatic measure(output int ha, output int hb);
        ha = 0; hb = 0;
        repeat (256) begin
            tick(1);
            ha += int'(o_pwm_bomba_a);
            hb += int'(o_pwm_bomba_b);
        end
    endtask

    initial begin
        int ha, hb, n;
        reset = 1'b0;
        tick(3);
        check("reset_ack", o_ack, 0);
        check("reset_state", o_state, 0);
        check("reset_fault", o_fault, 0);
        check("reset_pwm", {o_pwm_bomba_a, o_pwm_bomba_b}, 0);
        reset = 1'b1;
        tick(2);

        handshake(4'b0100, 1, "hs_0100");
        i_boia_cheia = 1'b1; tick(5); i_boia_cheia = 1'b0; tick(25);
        check("glitch_state", o_state, 1);
        measure(ha, hb);
        check("filter_duty_a", ha, 160);
        check("filter_duty_b", hb, 0);

        i_boia_cheia = 1'b1;
        tick(DEB + 2);
        check("cheia_edge_minus1", o_state, 1);
        tick(1);
        check("cheia_drain", o_state, 2);
        i_boia_cheia = 1'b0;
        measure(ha, hb);
        check("drain_duty_a", ha, 0);
        check("drain_duty_b", hb, 255);

        handshake(4'b0000, 3, "hs_stop");
        i_boia_vazia = 1'b1;
        tick(DEB + 3);
        check("vazia_idle", o_state, 0);
        i_boia_vazia = 1'b0;
        tick(DEB + 4);

        handshake(4'b1111, 1, "hs_1111");
        measure(ha, hb);
        check("sat_duty_a", ha, 255);
        i_boia_cheia = 1'b1; i_boia_vazia = 1'b1;
        tick(DEB + 3);
        check("both_floats_state", o_state, 4);
        check("both_floats_fault", o_fault, 1);
        handshake(4'b0000, 4, "hs_fault_inconsistent");
        i_boia_cheia = 1'b0; i_boia_vazia = 1'b0;
        tick(DEB + 4);
        handshake(4'b0011, 4, "hs_fault_nonzero");
        handshake(4'b0000, 0, "hs_fault_clear");
        check("fault_cleared", o_fault, 0);

        handshake(4'b0010, 1, "hs_timeout");
        n = 0;
        while (o_state != 3'd4 && n < 2 * TO) begin tick(1); n++; end
        check("timeout_cycles", n + 3, TO + 1);
        check("timeout_fault", o_fault, 1);

        i_dados = 4'b0001; i_req = 1'b1; n = 0;
        while (!o_ack && n < 20) begin tick(1); n++; end
        check("midhs_ack_up", o_ack, 1);
        reset = 1'b0;
        tick(1);
        check("midhs_reset_ack", o_ack, 0);
        check("midhs_reset_state", o_state, 0);
        reset = 1'b1; n = 0;
        while (!o_ack && n < 20) begin tick(1); n++; end
        check("midhs_reaccept_latency", n, 3);
        check("midhs_reaccept_state", o_state, 1);
        i_req = 1'b0;
        tick(6);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
